// File: rtl/gba_bus_ctrl.sv
// gba_bus_ctrl
//   Bus controller between the cpu_armv4t memory port and the GBA memory map.
//   Latches one CPU request, decodes its region, burns the region's wait
//   states, runs a single byte-enabled device access and returns a one-cycle
//   cpu_ok pulse with right-aligned, zero-extended read data.
//
// Ports
//   clk, rstn             clock, synchronous active-low reset
//   cpu_addr/wdata/width  request byte address, right-aligned write data, size
//   cpu_read/cpu_write    level requests held by the CPU until cpu_ok
//   cpu_ok/cpu_rdata      completion pulse and read data (valid with cpu_ok)
//   bus_err               fault flag, pulses together with cpu_ok
//   dev_sel/addr/req/we   device region, word address, strobe, direction
//   dev_be/dev_wdata      byte enables and lane-replicated write data
//   dev_rdata/dev_ack     device read data and completion
module gba_bus_ctrl #(
  parameter int WS_BIOS     = 0,
  parameter int WS_EWRAM    = 2,
  parameter int WS_IWRAM    = 0,
  parameter int WS_IO       = 0,
  parameter int WS_ROM      = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic        cpu_ok,
  output logic [31:0] cpu_rdata,
  output logic        bus_err,
  output logic [2:0]  dev_sel,
  output logic [31:0] dev_addr,
  output logic        dev_req,
  output logic        dev_we,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state, state_nxt;

  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [1:0]  width_p0;
  logic        we_p0;
  logic [2:0]  sel_p0;
  logic        err_p0;
  logic [7:0]  wcnt_p0;
  logic [7:0]  tcnt_p0;
  logic [31:0] rdata_p1;

  logic        req;
  logic [3:0]  dec;
  logic        fault;
  logic [7:0]  waits;

  // Returns {mapped, region}. BIOS only covers the first 16 KiB.
  function automatic logic [3:0] decode(input logic [31:0] a);
    logic [3:0] r;
    r = 4'b0000;
    if (a[31:28] == 4'h0) begin
      case (a[27:24])
        4'h0: if (a[23:14] == 10'd0) r = {1'b1, 3'd0};
        4'h2: r = {1'b1, 3'd1};
        4'h3: r = {1'b1, 3'd2};
        4'h4: r = {1'b1, 3'd3};
        4'h5: r = {1'b1, 3'd4};
        4'h6: r = {1'b1, 3'd5};
        4'h7: r = {1'b1, 3'd6};
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: r = {1'b1, 3'd7};
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] waits_of(input logic [2:0] sel);
    logic [7:0] w;
    case (sel)
      3'd0:    w = 8'(WS_BIOS);
      3'd1:    w = 8'(WS_EWRAM);
      3'd2:    w = 8'(WS_IWRAM);
      3'd7:    w = 8'(WS_ROM);
      default: w = 8'(WS_IO);
    endcase
    return w;
  endfunction

  function automatic logic [3:0] be_lanes(input logic [1:0] w, input logic [1:0] a);
    logic [3:0] be;
    case (w)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_lanes(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    case (w)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Misaligned half/word reads are force-aligned, never rotated.
  function automatic logic [31:0] rdata_extract(input logic [1:0] w, input logic [1:0] a,
                                                input logic [31:0] d);
    logic [31:0] r;
    case (w)
      2'd0:    r = {24'd0, d[{a, 3'b000} +: 8]};
      2'd1:    r = {16'd0, d[{a[1], 4'b0000} +: 16]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req   = cpu_read | cpu_write;
  assign dec   = decode(cpu_addr);
  assign fault = ~dec[3]
               | (cpu_write & ((dec[2:0] == 3'd0) | (dec[2:0] == 3'd7)))
               | (cpu_width == 2'd3)
               | (cpu_read & cpu_write);
  assign waits = waits_of(dec[2:0]);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) begin
        if (fault)              state_nxt = RESP;
        else if (waits != 8'd0) state_nxt = WAIT;
        else                    state_nxt = ACCESS;
      end
      WAIT:   if (wcnt_p0 == 8'd1) state_nxt = ACCESS;
      ACCESS: if (dev_ack || tcnt_p0 == 8'(ACK_TIMEOUT - 1)) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch (p0): counters and error flag are control and reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_p0  <= 1'b0;
      wcnt_p0 <= 8'd0;
      tcnt_p0 <= 8'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          err_p0  <= fault;
          wcnt_p0 <= waits;
          tcnt_p0 <= 8'd0;
        end
        WAIT: wcnt_p0 <= wcnt_p0 - 8'd1;
        ACCESS: if (!dev_ack) begin
          if (tcnt_p0 == 8'(ACK_TIMEOUT - 1)) err_p0 <= 1'b1;
          else                                tcnt_p0 <= tcnt_p0 + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_p0  <= cpu_addr;
      wdata_p0 <= cpu_wdata;
      width_p0 <= cpu_width;
      we_p0    <= cpu_write;
      sel_p0   <= dec[2:0];
    end
  end

  // Response capture (p1): cleared on latch so faults and timeouts return 0.
  always_ff @(posedge clk) begin
    if (state == IDLE && req)
      rdata_p1 <= 32'd0;
    else if (state == ACCESS && dev_ack)
      rdata_p1 <= we_p0 ? 32'd0 : rdata_extract(width_p0, addr_p0[1:0], dev_rdata);
  end

  // Data fields are only exposed in the state that owns them, so every
  // output is 0 after reset without resetting the datapath registers.
  always_comb begin
    cpu_ok    = 1'b0;
    bus_err   = 1'b0;
    cpu_rdata = 32'd0;
    dev_req   = 1'b0;
    dev_sel   = 3'd0;
    dev_addr  = 32'd0;
    dev_we    = 1'b0;
    dev_be    = 4'd0;
    dev_wdata = 32'd0;
    if (state == RESP) begin
      cpu_ok    = 1'b1;
      bus_err   = err_p0;
      cpu_rdata = rdata_p1;
    end
    if (state == ACCESS) begin
      dev_req   = 1'b1;
      dev_sel   = sel_p0;
      dev_addr  = {addr_p0[31:2], 2'b00};
      dev_we    = we_p0;
      dev_be    = we_p0 ? be_lanes(width_p0, addr_p0[1:0]) : 4'b1111;
      dev_wdata = wdata_lanes(width_p0, wdata_p0);
    end
  end

endmodule

// File: tb/tb_gba_bus_ctrl.sv
// Directed bench for gba_bus_ctrl: a vector table of single transactions
// with an always-acking device, plus sequences for timeout, reset in WAIT,
// withdrawn request and a request held across cpu_ok.
module tb_gba_bus_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dev_addr, dev_wdata, dev_rdata;
  logic [1:0]  cpu_width;
  logic        cpu_read, cpu_write, cpu_ok, bus_err, dev_req, dev_we, dev_ack;
  logic [2:0]  dev_sel;
  logic [3:0]  dev_be;

  int n_tests = 0;
  int n_fail  = 0;

  gba_bus_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_ok(cpu_ok), .cpu_rdata(cpu_rdata), .bus_err(bus_err),
    .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_req(dev_req), .dev_we(dev_we),
    .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        rd;
    logic        wr;
    logic [31:0] drd;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] dwd;
    logic [2:0]  sel;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {31'd0, |{cpu_ok, bus_err, cpu_rdata, dev_sel, dev_addr, dev_req,
                      dev_we, dev_be, dev_wdata}}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          cyc;
    logic        got, saw, we;
    logic [3:0]  be;
    logic [31:0] wd, ad;
    logic [2:0]  sl;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_width = v.width;
    cpu_read  = v.rd;
    cpu_write = v.wr;
    dev_rdata = v.drd;
    dev_ack   = 1'b1;
    cyc = 0; got = 1'b0; saw = 1'b0; we = 1'b0; be = '0; wd = '0; ad = '0; sl = '0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (dev_req) begin
        saw = 1'b1; be = dev_be; wd = dev_wdata; ad = dev_addr; sl = dev_sel; we = dev_we;
      end
      if (cpu_ok) begin
        got = 1'b1;
        chk({nm, "_lat"}, 32'(cyc), 32'(v.lat));
        chk({nm, "_err"}, {31'd0, bus_err}, {31'd0, v.err});
        chk({nm, "_rdata"}, cpu_rdata, v.rdata);
      end
    end
    if (!got) chk({nm, "_no_ok"}, 32'd0, 32'd1);
    chk({nm, "_req_seen"}, {31'd0, saw}, {31'd0, ~v.err});
    if (!v.err) begin
      chk({nm, "_be"}, {28'd0, be}, {28'd0, v.be});
      chk({nm, "_sel"}, {29'd0, sl}, {29'd0, v.sel});
      chk({nm, "_addr"}, ad, {v.addr[31:2], 2'b00});
      chk({nm, "_we"}, {31'd0, we}, {31'd0, v.wr});
      if (v.wr) chk({nm, "_wdata"}, wd, v.dwd);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    tick();
    chk({nm, "_ok_clear"}, {31'd0, cpu_ok}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic got;

    //             addr          wdata         w  rd wr drd           err lat rdata         be       dwd           sel
    vecs[0]  = '{32'h0300_0010, 32'h0,        2, 1, 0, 32'hDEADBEEF, 0,  2, 32'hDEADBEEF, 4'b1111, 32'h0,        3'd2};
    vecs[1]  = '{32'h0800_0002, 32'h0,        1, 1, 0, 32'h12345678, 0,  6, 32'h00001234, 4'b1111, 32'h0,        3'd7};
    vecs[2]  = '{32'h0200_0003, 32'h123456AB, 0, 0, 1, 32'h0,        0,  4, 32'h0,        4'b1000, 32'hABABABAB, 3'd1};
    vecs[3]  = '{32'h0800_0000, 32'h11,       2, 0, 1, 32'h0,        1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[4]  = '{32'h0100_0000, 32'h0,        2, 1, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[5]  = '{32'h0300_0000, 32'h0,        3, 1, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[6]  = '{32'h0300_0000, 32'h0,        2, 1, 1, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[7]  = '{32'h0000_0001, 32'h0,        0, 1, 0, 32'h11223344, 0,  2, 32'h00000033, 4'b1111, 32'h0,        3'd0};
    vecs[8]  = '{32'h0400_0006, 32'hFFFFBEEF, 1, 0, 1, 32'h0,        0,  2, 32'h0,        4'b1100, 32'hBEEFBEEF, 3'd3};
    vecs[9]  = '{32'h0600_0008, 32'hCAFEF00D, 2, 0, 1, 32'h0,        0,  2, 32'h0,        4'b1111, 32'hCAFEF00D, 3'd5};
    vecs[10] = '{32'h0000_4000, 32'h0,        2, 1, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[11] = '{32'h0700_0002, 32'h0,        0, 1, 0, 32'hA1B2C3D4, 0,  2, 32'h000000B2, 4'b1111, 32'h0,        3'd6};
    vecs[12] = '{32'h0500_0003, 32'h0,        2, 1, 0, 32'h87654321, 0,  2, 32'h87654321, 4'b1111, 32'h0,        3'd4};
    vecs[13] = '{32'h1300_0000, 32'h0,        2, 1, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};
    vecs[14] = '{32'h0D00_0000, 32'h0,        2, 1, 0, 32'h00000005, 0,  6, 32'h00000005, 4'b1111, 32'h0,        3'd7};
    vecs[15] = '{32'h0E00_0000, 32'h0,        2, 1, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        4'b0000, 32'h0,        3'd0};

    rstn = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_width = '0; cpu_read = 1'b0;
    cpu_write = 1'b0; dev_rdata = '0; dev_ack = 1'b0;
    repeat (3) tick();
    all_zero("reset_outputs");
    rstn = 1'b1;
    tick();
    all_zero("idle_outputs");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Device never acks: cpu_ok/bus_err land 255 cycles after ACCESS entry (cycle 1).
    cpu_addr = 32'h0300_0000; cpu_width = 2; cpu_read = 1'b1; dev_ack = 1'b0;
    dev_rdata = 32'hFFFFFFFF;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      tick();
      cyc++;
      if (cpu_ok) begin
        got = 1'b1;
        chk("timeout_lat", 32'(cyc), 32'd256);
        chk("timeout_err", {31'd0, bus_err}, 32'd1);
        chk("timeout_rdata", cpu_rdata, 32'd0);
        chk("timeout_req_low", {31'd0, dev_req}, 32'd0);
      end
    end
    if (!got) chk("timeout_no_ok", 32'd0, 32'd1);
    cpu_read = 1'b0;
    tick();

    // Reset while in WAIT abandons the ROM access.
    cpu_addr = 32'h0800_0000; cpu_width = 2; cpu_read = 1'b1; dev_ack = 1'b1;
    tick(); tick();
    rstn = 1'b0; cpu_read = 1'b0;
    tick();
    all_zero("rst_in_wait");
    rstn = 1'b1;
    tick();
    all_zero("rst_in_wait_idle");
    run_vec(vecs[0], "after_rst");

    // Withdrawn EWRAM read still completes at cycle 4.
    cpu_addr = 32'h0200_0000; cpu_width = 2; cpu_read = 1'b1; dev_ack = 1'b1;
    dev_rdata = 32'h0BADF00D;
    tick();
    cpu_read = 1'b0;
    tick(); tick();
    chk("withdraw_req", {31'd0, dev_req}, 32'd1);
    tick();
    chk("withdraw_ok", {31'd0, cpu_ok}, 32'd1);
    chk("withdraw_rdata", cpu_rdata, 32'h0BADF00D);
    tick();
    chk("withdraw_idle_req", {31'd0, dev_req}, 32'd0);
    tick();
    chk("withdraw_no_new", {31'd0, dev_req | cpu_ok}, 32'd0);

    // Request held across cpu_ok: one idle cycle, then a second access.
    cpu_addr = 32'h0300_0004; cpu_width = 2; cpu_read = 1'b1; dev_rdata = 32'h00C0FFEE;
    tick();
    chk("held_req1", {31'd0, dev_req}, 32'd1);
    tick();
    chk("held_ok1", {31'd0, cpu_ok}, 32'd1);
    tick();
    chk("held_gap", {31'd0, cpu_ok | dev_req}, 32'd0);
    tick();
    chk("held_req2", {31'd0, dev_req}, 32'd1);
    tick();
    chk("held_ok2", {31'd0, cpu_ok}, 32'd1);
    chk("held_rdata2", cpu_rdata, 32'h00C0FFEE);
    cpu_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
